// File: rtl/hazard_control_pkg.sv
// Shared opcode/funct encodings, ALU operation codes and the ID/EX control bundle
// used by the ID-stage hazard control unit.
package hazard_control_pkg;

  localparam logic [5:0] OPCODE_RTYPE = 6'h00;
  localparam logic [5:0] OPCODE_J     = 6'h02;
  localparam logic [5:0] OPCODE_BEQ   = 6'h04;
  localparam logic [5:0] OPCODE_BNE   = 6'h05;
  localparam logic [5:0] OPCODE_ADDI  = 6'h08;
  localparam logic [5:0] OPCODE_ADDIU = 6'h09;
  localparam logic [5:0] OPCODE_SLTI  = 6'h0A;
  localparam logic [5:0] OPCODE_ANDI  = 6'h0C;
  localparam logic [5:0] OPCODE_ORI   = 6'h0D;
  localparam logic [5:0] OPCODE_LW    = 6'h23;
  localparam logic [5:0] OPCODE_SW    = 6'h2B;
  localparam logic [5:0] OPCODE_HALT  = 6'h3F;

  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;

  typedef enum logic [2:0] {
    ALU_OP_ADD   = 3'b000,
    ALU_OP_SUB   = 3'b001,
    ALU_OP_RTYPE = 3'b010,
    ALU_OP_AND   = 3'b011,
    ALU_OP_OR    = 3'b100,
    ALU_OP_SLT   = 3'b101
  } alu_op_e;

  typedef struct packed {
    logic    reg_dst;
    logic    alu_src;
    logic    mem_read;
    logic    mem_write;
    logic    mem_to_reg;
    logic    reg_write;
    logic    branch;
    logic    jump;
    alu_op_e alu_op;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

  typedef enum logic {
    ST_RUN    = 1'b0,
    ST_HALTED = 1'b1
  } state_e;

  function automatic logic is_muldiv_funct(input logic [5:0] f);
    return (f == FUNCT_MULT) || (f == FUNCT_MULTU) ||
           (f == FUNCT_DIV)  || (f == FUNCT_DIVU);
  endfunction

  function automatic logic is_hilo_read(input logic [5:0] f);
    return (f == FUNCT_MFHI) || (f == FUNCT_MFLO);
  endfunction

  // Instructions that actually read the rt field as a source operand.
  function automatic logic uses_rt(input logic [5:0] op);
    return (op == OPCODE_RTYPE) || (op == OPCODE_SW) ||
           (op == OPCODE_BEQ)   || (op == OPCODE_BNE);
  endfunction

endpackage

// File: rtl/hazard_control_main_decoder.sv
// Combinational opcode-to-control-bundle decoder; a low enable yields the
// all-zero bundle, so the same block doubles as the bubble source.
module hazard_control_main_decoder
  import hazard_control_pkg::*;
(
  input  logic       en,
  input  logic [5:0] opcode,
  output ctrl_t      ctrl
);

  always_comb begin
    ctrl = CTRL_NOP;
    if (en) begin
      case (opcode)
        OPCODE_RTYPE: begin
          ctrl.reg_dst   = 1'b1;
          ctrl.alu_op    = ALU_OP_RTYPE;
          ctrl.reg_write = 1'b1;
        end
        OPCODE_ADDI, OPCODE_ADDIU: begin
          ctrl.alu_src   = 1'b1;
          ctrl.alu_op    = ALU_OP_ADD;
          ctrl.reg_write = 1'b1;
        end
        OPCODE_ANDI: begin
          ctrl.alu_src   = 1'b1;
          ctrl.alu_op    = ALU_OP_AND;
          ctrl.reg_write = 1'b1;
        end
        OPCODE_ORI: begin
          ctrl.alu_src   = 1'b1;
          ctrl.alu_op    = ALU_OP_OR;
          ctrl.reg_write = 1'b1;
        end
        OPCODE_SLTI: begin
          ctrl.alu_src   = 1'b1;
          ctrl.alu_op    = ALU_OP_SLT;
          ctrl.reg_write = 1'b1;
        end
        OPCODE_LW: begin
          ctrl.alu_src    = 1'b1;
          ctrl.alu_op     = ALU_OP_ADD;
          ctrl.mem_read   = 1'b1;
          ctrl.mem_to_reg = 1'b1;
          ctrl.reg_write  = 1'b1;
        end
        OPCODE_SW: begin
          ctrl.alu_src   = 1'b1;
          ctrl.alu_op    = ALU_OP_ADD;
          ctrl.mem_write = 1'b1;
        end
        OPCODE_BEQ, OPCODE_BNE: begin
          ctrl.alu_op = ALU_OP_SUB;
          ctrl.branch = 1'b1;
        end
        OPCODE_J: begin
          ctrl.jump = 1'b1;
        end
        // HALT and unknown opcodes leave the bundle at all-zero.
        default: begin
          ctrl = CTRL_NOP;
        end
      endcase
    end
  end

endmodule

// File: rtl/hazard_control.sv
// ID-stage control unit: decode, load-use and MULT/DIV scoreboard stalls,
// IF/ID flush on taken branches/jumps, and a sticky HALT state.
module hazard_control
  import hazard_control_pkg::*;
#(
  parameter int MULDIV_LAT = 4,
  parameter int ALU_OP_W   = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [5:0]          opcode,
  input  logic [5:0]          funct,
  input  logic [4:0]          rs,
  input  logic [4:0]          rt,
  input  logic                id_ex_mem_read,
  input  logic [4:0]          id_ex_rt,
  input  logic                branch_taken,
  output logic                reg_dst,
  output logic                alu_src,
  output logic                mem_read,
  output logic                mem_write,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                branch,
  output logic                jump,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                muldiv_start,
  output logic                pc_write,
  output logic                if_id_write,
  output logic                if_id_flush,
  output logic                halted
);

  localparam int CNT_W = 4;

  state_e           state_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic             is_rtype;
  logic             muldiv_op;
  logic             hilo_read;
  logic [1:0][4:0]  src_regs;
  logic [1:0]       src_used;
  logic [1:0]       src_hit;
  logic             load_use_stall;
  logic             muldiv_stall;
  logic             stall;
  logic             issue_ok;
  logic             advance;
  ctrl_t            ctrl;

  assign is_rtype  = (opcode == OPCODE_RTYPE);
  assign muldiv_op = is_rtype && is_muldiv_funct(funct);
  assign hilo_read = is_rtype && is_hilo_read(funct);

  // Slot 0 is rs (always read), slot 1 is rt (read only by some formats).
  assign src_regs = {rt, rs};
  assign src_used = {uses_rt(opcode), 1'b1};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_src_hit
      assign src_hit[gi] = src_used[gi] && (src_regs[gi] == id_ex_rt);
    end
  endgenerate

  assign load_use_stall = id_ex_mem_read && (id_ex_rt != 5'd0) && (|src_hit);
  assign muldiv_stall   = (cnt_reg != '0) && (muldiv_op || hilo_read);
  assign stall          = load_use_stall || muldiv_stall;

  // issue_ok feeds the state registers; advance additionally forces every
  // output low while reset is held, independent of the clock.
  assign issue_ok = (state_reg == ST_RUN) && !stall;
  assign advance  = rst_n && issue_ok;

  hazard_control_main_decoder u_main_decoder (
    .en     (advance),
    .opcode (opcode),
    .ctrl   (ctrl)
  );

  assign reg_dst    = ctrl.reg_dst;
  assign alu_src    = ctrl.alu_src;
  assign mem_read   = ctrl.mem_read;
  assign mem_write  = ctrl.mem_write;
  assign mem_to_reg = ctrl.mem_to_reg;
  assign reg_write  = ctrl.reg_write;
  assign branch     = ctrl.branch;
  assign jump       = ctrl.jump;
  assign alu_op     = ALU_OP_W'(ctrl.alu_op);

  assign muldiv_start = advance && muldiv_op;
  assign pc_write     = advance;
  assign if_id_write  = advance;
  assign if_id_flush  = advance && (branch_taken || (opcode == OPCODE_J));
  assign halted       = (state_reg == ST_HALTED);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_RUN;
      cnt_reg   <= '0;
    end else begin
      if (issue_ok && (opcode == OPCODE_HALT)) begin
        state_reg <= ST_HALTED;
      end
      // A new MULT/DIV can only issue once the counter has drained, so the
      // reload never overlaps a running countdown.
      if (issue_ok && muldiv_op) begin
        cnt_reg <= CNT_W'(MULDIV_LAT);
      end else if (cnt_reg != '0) begin
        cnt_reg <= cnt_reg - CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_hazard_control.sv
// Self-checking bench for hazard_control: decode table, hand-written hazard
// sequences and randomized traffic against a cycle-number reference model.
`timescale 1ns/1ps
module tb_hazard_control;

  localparam int LAT = 4;

  // Observed vector: {reg_dst,alu_src,mem_read,mem_write,mem_to_reg,reg_write,
  //                   branch,jump, alu_op[2:0], muldiv_start,pc_write,if_id_write,if_id_flush,halted}
  localparam logic [15:0] E_ADDI   = {8'b01000100, 3'b000, 5'b01100};
  localparam logic [15:0] E_R      = {8'b10000100, 3'b010, 5'b01100};
  localparam logic [15:0] E_LW     = {8'b01101100, 3'b000, 5'b01100};
  localparam logic [15:0] E_SW     = {8'b01010000, 3'b000, 5'b01100};
  localparam logic [15:0] E_BEQ_T  = {8'b00000010, 3'b001, 5'b01110};
  localparam logic [15:0] E_BNE_N  = {8'b00000010, 3'b001, 5'b01100};
  localparam logic [15:0] E_UNK    = {8'b00000000, 3'b000, 5'b01100};
  localparam logic [15:0] E_J      = {8'b00000001, 3'b000, 5'b01110};
  localparam logic [15:0] E_ANDI   = {8'b01000100, 3'b011, 5'b01100};
  localparam logic [15:0] E_ORI    = {8'b01000100, 3'b100, 5'b01100};
  localparam logic [15:0] E_SLTI   = {8'b01000100, 3'b101, 5'b01100};
  localparam logic [15:0] E_MULT   = {8'b10000100, 3'b010, 5'b11100};
  localparam logic [15:0] E_HALTID = {8'b00000000, 3'b000, 5'b01100};
  localparam logic [15:0] E_HALTED = 16'h0001;
  localparam logic [15:0] E_BUBBLE = 16'h0000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [5:0] opcode, funct;
  logic [4:0] rs, rt, id_ex_rt;
  logic       id_ex_mem_read, branch_taken;
  logic       reg_dst, alu_src, mem_read, mem_write, mem_to_reg, reg_write, branch, jump;
  logic [2:0] alu_op;
  logic       muldiv_start, pc_write, if_id_write, if_id_flush, halted;
  logic [15:0] obs;

  hazard_control #(.MULDIV_LAT(LAT), .ALU_OP_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .rs(rs), .rt(rt),
    .id_ex_mem_read(id_ex_mem_read), .id_ex_rt(id_ex_rt), .branch_taken(branch_taken),
    .reg_dst(reg_dst), .alu_src(alu_src), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .reg_write(reg_write), .branch(branch), .jump(jump),
    .alu_op(alu_op), .muldiv_start(muldiv_start), .pc_write(pc_write),
    .if_id_write(if_id_write), .if_id_flush(if_id_flush), .halted(halted)
  );

  assign obs = {reg_dst, alu_src, mem_read, mem_write, mem_to_reg, reg_write, branch, jump,
                alu_op, muldiv_start, pc_write, if_id_write, if_id_flush, halted};

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state: cycle index, cycle at which HI/LO become readable, halt flag.
  int   cyc = 0;
  int   ready_at = 0;
  logic m_halted = 1'b0;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        mr;
    logic [4:0]  ert;
    logic        bt;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[18];

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h (t=%0t)", name, got, exp, $time);
    end else begin
      $display("ok   %s: %h", name, got);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] a,
                       input logic [4:0] b, input logic mr, input logic [4:0] ert, input logic bt);
    opcode = op; funct = fn; rs = a; rt = b;
    id_ex_mem_read = mr; id_ex_rt = ert; branch_taken = bt;
  endtask

  function automatic logic [10:0] ref_bundle(input logic [5:0] op);
    case (op)
      6'h00:        return {8'b10000100, 3'b010};
      6'h08, 6'h09: return {8'b01000100, 3'b000};
      6'h0C:        return {8'b01000100, 3'b011};
      6'h0D:        return {8'b01000100, 3'b100};
      6'h0A:        return {8'b01000100, 3'b101};
      6'h23:        return {8'b01101100, 3'b000};
      6'h2B:        return {8'b01010000, 3'b000};
      6'h04, 6'h05: return {8'b00000010, 3'b001};
      6'h02:        return {8'b00000001, 3'b000};
      default:      return 11'd0;
    endcase
  endfunction

  function automatic logic m_is_mdu();
    return (opcode == 6'h00) && (funct inside {6'h18, 6'h19, 6'h1A, 6'h1B});
  endfunction

  function automatic logic m_stall();
    logic hilo, rt_used, lu, ms;
    hilo    = (opcode == 6'h00) && (funct inside {6'h10, 6'h12});
    rt_used = opcode inside {6'h00, 6'h2B, 6'h04, 6'h05};
    lu      = id_ex_mem_read && (id_ex_rt != 5'd0) &&
              ((id_ex_rt == rs) || (rt_used && (id_ex_rt == rt)));
    ms      = (cyc < ready_at) && (m_is_mdu() || hilo);
    return lu || ms;
  endfunction

  function automatic logic [15:0] model_out();
    if (m_halted) return E_HALTED;
    if (m_stall()) return E_BUBBLE;
    return {ref_bundle(opcode), m_is_mdu(), 1'b1, 1'b1,
            branch_taken || (opcode == 6'h02), 1'b0};
  endfunction

  function automatic void model_update();
    if (!m_halted && !m_stall()) begin
      if (opcode == 6'h3F) m_halted = 1'b1;
      if (m_is_mdu()) ready_at = cyc + 1 + LAT;
    end
    cyc++;
  endfunction

  // Called at posedge+1: check at the falling edge, then clock the model.
  task automatic expect_cycle(input string name, input logic [15:0] exp);
    @(negedge clk);
    check(name, obs, exp);
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic stall_until_go(input string name, output int stalls);
    stalls = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (pc_write) break;
      check(name, obs, E_BUBBLE);
      stalls++;
      @(posedge clk);
      model_update();
      #1;
    end
  endtask

  task automatic do_reset(input string name);
    #1 rst_n = 1'b0;
    #1 check(name, obs, E_BUBBLE);
    m_halted = 1'b0;
    ready_at = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    model_update();
    #1;
  endtask

  initial begin
    int stalls;
    int halt_cycles;
    logic [5:0] ops[14];
    logic [5:0] fns[8];

    vecs[0]  = '{6'h08, 6'h00, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, E_ADDI};
    vecs[1]  = '{6'h00, 6'h20, 5'd8, 5'd9, 1'b1, 5'd8, 1'b0, E_BUBBLE};
    vecs[2]  = '{6'h00, 6'h20, 5'd8, 5'd9, 1'b0, 5'd8, 1'b0, E_R};
    vecs[3]  = '{6'h23, 6'h00, 5'd3, 5'd4, 1'b1, 5'd5, 1'b0, E_LW};
    vecs[4]  = '{6'h2B, 6'h00, 5'd3, 5'd4, 1'b0, 5'd0, 1'b0, E_SW};
    vecs[5]  = '{6'h04, 6'h00, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1, E_BEQ_T};
    vecs[6]  = '{6'h04, 6'h00, 5'd1, 5'd2, 1'b1, 5'd2, 1'b1, E_BUBBLE};
    vecs[7]  = '{6'h08, 6'h00, 5'd0, 5'd0, 1'b1, 5'd0, 1'b0, E_ADDI};
    vecs[8]  = '{6'h3E, 6'h00, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, E_UNK};
    vecs[9]  = '{6'h02, 6'h00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, E_J};
    vecs[10] = '{6'h0C, 6'h00, 5'd1, 5'd7, 1'b1, 5'd7, 1'b0, E_ANDI};
    vecs[11] = '{6'h0D, 6'h00, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, E_ORI};
    vecs[12] = '{6'h0A, 6'h00, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, E_SLTI};
    vecs[13] = '{6'h05, 6'h00, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, E_BNE_N};
    vecs[14] = '{6'h2B, 6'h00, 5'd1, 5'd6, 1'b1, 5'd6, 1'b0, E_BUBBLE};
    vecs[15] = '{6'h00, 6'h12, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, E_R};
    vecs[16] = '{6'h09, 6'h00, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0, E_ADDI};
    vecs[17] = '{6'h02, 6'h00, 5'd5, 5'd0, 1'b1, 5'd5, 1'b0, E_BUBBLE};

    ops = '{6'h00, 6'h00, 6'h00, 6'h02, 6'h04, 6'h05, 6'h08,
            6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h23, 6'h2B, 6'h3E};
    fns = '{6'h18, 6'h19, 6'h1A, 6'h1B, 6'h10, 6'h12, 6'h20, 6'h2A};

    rst_n = 1'b0;
    drive(6'h00, 6'h00, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    #3 check("reset_state", obs, E_BUBBLE);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    model_update();
    #1;

    for (int i = 0; i < 18; i++) begin
      drive(vecs[i].op, vecs[i].fn, vecs[i].rs, vecs[i].rt, vecs[i].mr, vecs[i].ert, vecs[i].bt);
      expect_cycle($sformatf("table[%0d] op=%h", i, vecs[i].op), vecs[i].exp);
    end

    // MULT followed by a dependent MFLO.
    drive(6'h00, 6'h18, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0);
    expect_cycle("mult_issue", E_MULT);
    drive(6'h00, 6'h12, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    stall_until_go("mflo_stall", stalls);
    check("mflo_stall_len", 16'(stalls), 16'(LAT));
    check("mflo_go", obs, E_R);
    @(posedge clk); model_update(); #1;

    // Back-to-back MULTs: the second waits for the countdown, then issues.
    drive(6'h00, 6'h19, 5'd1, 5'd2, 1'b0, 5'd0, 1'b0);
    expect_cycle("mult2_issue", E_MULT);
    drive(6'h00, 6'h1A, 5'd3, 5'd4, 1'b0, 5'd0, 1'b0);
    stall_until_go("div_stall", stalls);
    check("div_stall_len", 16'(stalls), 16'(LAT));
    check("div_issue", obs, E_MULT);
    @(posedge clk); model_update(); #1;

    // HALT while the counter is still busy, then async reset mid-countdown.
    drive(6'h3F, 6'h00, 5'd9, 5'd9, 1'b0, 5'd0, 1'b1);
    expect_cycle("halt_in_id", E_HALTID | 16'h0002);
    drive(6'h08, 6'h00, 5'd1, 5'd2, 1'b0, 5'd0, 1'b1);
    for (int i = 0; i < 3; i++) expect_cycle($sformatf("halted[%0d]", i), E_HALTED);
    do_reset("reset_async");
    drive(6'h00, 6'h10, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0);
    expect_cycle("mfhi_after_reset", E_R);

    // Randomized traffic against the reference model.
    halt_cycles = 0;
    for (int i = 0; i < 1500; i++) begin
      if (m_halted && halt_cycles >= 3) begin
        do_reset($sformatf("rand_reset[%0d]", i));
        halt_cycles = 0;
      end
      drive(($urandom_range(0, 79) == 0) ? 6'h3F : ops[$urandom_range(0, 13)],
            fns[$urandom_range(0, 7)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      if (m_halted) halt_cycles++;
      expect_cycle($sformatf("rand[%0d] op=%h fn=%h", i, opcode, funct), model_out());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/hazard_control.md
# hazard_control

Pipelined control unit for the MIPS core's ID stage. It replaces the purely combinational opcode decoder, which had no state. Every cycle it decodes the ID-stage instruction into the control bundle. It also owns stall and bubble generation for load-use hazards, a countdown scoreboard for the multi-cycle MULT/DIV unit, IF/ID flush on taken branches and jumps, and a sticky HALT state. Its outputs drive the ID/EX register, the PC write enable and the IF/ID register.

## Interface
- MULDIV_LAT, 4: cycles from MULT/DIV issue until HI/LO are readable. Legal range 1..15.
- ALU_OP_W, 3: width of `alu_op`.
- clk  in  1  core clock; all state updates on the rising edge
- rst_n  in  1  reset, asynchronous and active-low
- opcode  in  6  ID instruction [31:26]
- funct  in  6  ID instruction [5:0]
- rs, rt  in  5 each  ID source register fields
- id_ex_mem_read  in  1  instruction in EX is a load
- id_ex_rt  in  5  destination register of the instruction in EX
- branch_taken  in  1  branch comparison in ID resolved taken
- reg_dst, alu_src, mem_read, mem_write, mem_to_reg, reg_write, branch, jump  out  1 each  control bundle to ID/EX
- alu_op  out  ALU_OP_W  ADD=000, SUB=001, RTYPE=010, AND=011, OR=100, SLT=101
- muldiv_start  out  1  issue pulse to the MULT/DIV unit
- pc_write, if_id_write  out  1 each  pipeline advance enables
- if_id_flush  out  1  zero the IF/ID register on the next edge
- halted  out  1  core is stopped

## Operation
- **Decode.** All outputs are combinational from the inputs, the FSM state and the scoreboard counter.
  - R-type: rd, RTYPE, reg_write.
  - ADDI/ADDIU: imm, ADD. ANDI: imm, AND. ORI: imm, OR. SLTI: imm, SLT. All four set reg_write.
  - LW: imm, ADD, mem_read, mem_to_reg, reg_write. SW: imm, ADD, mem_write.
  - BEQ/BNE: SUB, branch. J (0x02): jump.
  - HALT (0x3F): no bundle outputs set.
  - Any unknown opcode produces the all-zero bundle.
- **Bubble.** Every bundle bit and `alu_op` is forced to 0, and `muldiv_start` is 0.
- **FSM states.**
  - RUN: normal operation.
  - HALTED: entered on the edge after a HALT is in ID while unstalled. It is left only through reset.
  - In HALTED: bubble, `pc_write`=`if_id_write`=0, `halted`=1.
- **Load-use stall.** Asserted when `id_ex_mem_read`, `id_ex_rt`≠0, and either `id_ex_rt`==`rs`, or `id_ex_rt`==`rt` with rt in use. rt is in use for R-type, SW, BEQ and BNE.
- **MULT/DIV scoreboard.**
  - An R-type instruction with funct 0x18/0x19/0x1A/0x1B issues when unstalled. Issue sets `muldiv_start`=1 and loads `cnt`=MULDIV_LAT.
  - `cnt` decrements every cycle while it is greater than 0.
  - Muldiv stall: `cnt`≠0 and the ID instruction is MFHI (0x10), MFLO (0x12) or another MULT/DIV.
- **Stall.** The OR of the load-use and muldiv stall conditions. While stalled: bubble, `pc_write`=`if_id_write`=0, and HALT and MULT/DIV do not take effect.
- **Flush.** `if_id_flush` = (`branch_taken` or J) and not stalled and not halted.
- **Priority:** HALTED > stall > flush > normal.

## Timing
- **Reset** (while `rst_n`=0, asynchronous): state=RUN, `cnt`=0. All bundle outputs, `muldiv_start`, `pc_write`, `if_id_write`, `if_id_flush` and `halted` are 0.
- **After reset release:** `pc_write`=`if_id_write`=1 from the first cycle, unless a stall applies.
- **Decode latency:** 0 cycles (combinational).
- **Load-use stall:** exactly 1 cycle per hazard, because the load leaves EX on the next edge.
- **MULT/DIV:** issued at edge t. A dependent instruction stalls for MULDIV_LAT cycles and issues in cycle t+MULDIV_LAT.
- **Back-to-back MULT:** the second stalls until `cnt`=0, then reloads the counter. No overlap.
- **HALT with `cnt`≠0:** HALTED is entered anyway and `cnt` keeps counting down to 0.
- **Reset mid-stall or mid-countdown:** immediate return to reset values.

## Structure
- **mips_pkg.vh additions:** OPCODE_J, OPCODE_HALT, FUNCT_MULT/MULTU/DIV/DIVU/MFHI/MFLO, and the ALU_OP_* 3-bit encodings.
- **Sub-module `main_decoder`:** pure combinational opcode-to-bundle decode, also used as the bubble source via an enable input.
- **Top level:** owns the FSM, `cnt` and the hazard logic.

## Test plan
- **ADDI decode, then load-use:** ADDI in ID → alu_src=1, alu_op=000, reg_write=1. Then `id_ex_mem_read`=1, `id_ex_rt`=8, R-type with rs=8 → one cycle of bubble with `pc_write`=0, then normal decode.
- **MULT scoreboard:** MULT then MFLO with MULDIV_LAT=4 → `muldiv_start` pulses once, MFLO stalls 4 cycles, `cnt` reads 4,3,2,1,0.
- **Taken branch:** BEQ in ID with `branch_taken`=1 → branch=1, `if_id_flush`=1. Same stimulus during a load-use stall → flush=0.
- **HALT:** HALT in ID → `halted`=1 on the next edge, `pc_write`=0 permanently. Assert `rst_n`=0 → RUN, all outputs 0 asynchronously.
- **Register $0:** `id_ex_rt`=0 with a matching rs → no stall.
- **Unknown opcode:** opcode 0x3E → all-zero bundle, `pc_write`=1.
